spi_master_mode1: RTL and testbench
===================================

SPI_MASTER_MODE1 -- requirements
Module: spi_master_mode1

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per SCLK half-period; legal range 1..255.
REQ-002 Parameter FRAME_LEN, default 8: bits per frame (1 register-address bit + 7 data bits).
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request one frame; sampled only in IDLE.
REQ-006 tx_addr  input  1  slave register address (0 = register 1, 1 = register 2); first bit on the wire.
REQ-007 tx_data  input  7  payload, MSB first after tx_addr.
REQ-008 miso  input  1  serial data from the slave.
REQ-009 chipSelect  output  1  slave select, active-low.
REQ-010 sclk  output  1  SPI clock, mode 1 (CPOL=0, CPHA=1).
REQ-011 mosi  output  1  serial data to the slave.
REQ-012 rx_data  output  8  last received frame, first-received bit in [7].
REQ-013 busy  output  1  high from the edge after start is accepted until the return to IDLE.
REQ-014 done  output  1  one-cycle pulse at frame end.

Function
REQ-015 The FSM SHALL have the states IDLE, SETUP, SCLK_HI, SCLK_LO, HOLD and DONE, and every output SHALL be registered.
REQ-016 IDLE: chipSelect=1, sclk=0, mosi=0, busy=0; when start=1 at edge E0, the block SHALL latch {tx_addr,tx_data} into an 8-bit shift register, drive chipSelect=0 and busy=1, and enter SETUP.
REQ-017 SETUP SHALL last CLK_DIV cycles with sclk=0 and mosi=0.
REQ-018 On entry to SCLK_HI, sclk SHALL go to 1 and mosi SHALL take shift[7], both on the same edge (mode 1 leading edge drives); the state SHALL last CLK_DIV cycles.
REQ-019 On entry to SCLK_LO, sclk SHALL go to 0, miso SHALL be sampled on that same edge into the receive register LSB with a left shift, the transmit shift register SHALL shift left, and the 3-bit bit counter SHALL increment; the state SHALL last CLK_DIV cycles.
REQ-020 From SCLK_LO, the FSM SHALL go to SCLK_HI when the bit counter is below FRAME_LEN, and to HOLD after the 8th low phase.
REQ-021 HOLD SHALL last CLK_DIV cycles with chipSelect=0, sclk=0 and mosi held.
REQ-022 DONE SHALL be entered at edge E0+18*CLK_DIV, drive chipSelect=1, done=1 and rx_data=receive register for one cycle, and then return to IDLE with busy=0.
REQ-023 Each frame SHALL produce exactly 8 sclk rising edges.
REQ-024 start asserted while busy=1, or in the DONE cycle, SHALL be ignored.
REQ-025 tx_addr and tx_data changes after E0 SHALL NOT affect the frame in flight.
REQ-026 A start held high continuously SHALL yield back-to-back frames with chipSelect high for at least 2 cycles (DONE and IDLE) between them.
REQ-027 rx_data SHALL change only in DONE.
REQ-028 With CLK_DIV=1, the sclk period SHALL be 2 clk cycles and the frame length SHALL be 18 cycles from E0 to DONE.

Reset
REQ-029 While rst=0 at a clk edge: state=IDLE, chipSelect=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0, and all counters and shift registers cleared.
REQ-030 A reset asserted mid-frame SHALL abort the frame on that edge with no done pulse, no rx_data update and no further sclk edge.

Structure
REQ-031 Package spi_pkg SHALL hold the state encodings (4-bit, IDLE=0), FRAME_LEN and the default CLK_DIV; it is shared with the slave-side control unit.
REQ-032 A single sub-module, spi_half_period_timer, SHALL provide a loadable down-counter that emits a one-cycle tick after CLK_DIV cycles; the FSM SHALL advance on that tick.
REQ-033 The implementation SHALL be pure synchronous RTL with no latches, no tri-states and no clock gating.

Verification
REQ-034 Bench with CLK_DIV=2, tx_addr=0, tx_data=7'h55, start for 1 cycle -> mosi on successive sclk rising edges = 0,1,0,1,0,1,0,1; done exactly 36 cycles after E0; chipSelect low for 36 cycles.
REQ-035 Bench with tx_addr=1, tx_data=7'h00 and miso driven 1,0,1,1,0,0,1,0 on the falling edges -> rx_data=8'hB2 at done; first mosi bit=1.
REQ-036 Bench with start re-pulsed at E0+5 and E0+20 (CLK_DIV=2) -> a single frame, exactly 8 sclk rising edges, one done.
REQ-037 Bench with rst=0 at E0+11 (CLK_DIV=2) -> next edge shows chipSelect=1, sclk=0, busy=0, no done, rx_data=0; a subsequent start runs a clean frame.
REQ-038 Bench with CLK_DIV=1 and start held high for 60 cycles -> 3 complete frames of 18 cycles each, chipSelect high for 2 cycles between frames, sclk never glitching high outside chipSelect=0.
REQ-039 Bench with tx_data changed at E0+3 -> transmitted bits match the value latched at E0.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI state encodings and frame constants.
package spi_pkg;

    localparam int SPI_FRAME_LEN       = 8;
    localparam int SPI_CLK_DIV_DEFAULT = 4;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_SETUP   = 4'd1,
        ST_SCLK_HI = 4'd2,
        ST_SCLK_LO = 4'd3,
        ST_HOLD    = 4'd4,
        ST_DONE    = 4'd5
    } spi_state_e;

endpackage

// File: rtl/spi_half_period_timer.sv
// rtl/spi_half_period_timer.sv - loadable down-counter ticking once per SCLK half-period.
module spi_half_period_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic tick
);

    logic [7:0] cnt;

    // Loading CLK_DIV-1 makes the tick land exactly CLK_DIV cycles after the load edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= 8'd0;
        end else if (load) begin
            cnt <= 8'(CLK_DIV - 1);
        end else if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign tick = run && (cnt == 8'd0);

endmodule

// File: rtl/spi_master_mode1.sv
// rtl/spi_master_mode1.sv - SPI mode 1 master sending one address bit plus 7 data bits per frame.
module spi_master_mode1
    import spi_pkg::*;
#(
    parameter int CLK_DIV   = SPI_CLK_DIV_DEFAULT,
    parameter int FRAME_LEN = SPI_FRAME_LEN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       tx_addr,
    input  logic [6:0] tx_data,
    input  logic       miso,
    output logic       chipSelect,
    output logic       sclk,
    output logic       mosi,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       done
);

    localparam int CNT_W = $clog2(FRAME_LEN);

    spi_state_e state, state_n;
    logic [7:0] shift_tx, shift_tx_n;
    logic [7:0] shift_rx, shift_rx_n;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
    logic cs_nxt, sclk_nxt, mosi_nxt, busy_nxt, done_nxt;
    logic [7:0] rx_nxt;
    logic load, tick, run;

    assign run = (state != ST_IDLE) && (state != ST_DONE);

    spi_half_period_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .run  (run),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            shift_tx   <= 8'd0;
            shift_rx   <= 8'd0;
            bit_cnt    <= '0;
            chipSelect <= 1'b1;
            sclk       <= 1'b0;
            mosi       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rx_data    <= 8'd0;
        end else begin
            state      <= state_n;
            shift_tx   <= shift_tx_n;
            shift_rx   <= shift_rx_n;
            bit_cnt    <= bit_cnt_n;
            chipSelect <= cs_nxt;
            sclk       <= sclk_nxt;
            mosi       <= mosi_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            rx_data    <= rx_nxt;
        end
    end

    always_comb begin
        state_n    = state;
        shift_tx_n = shift_tx;
        shift_rx_n = shift_rx;
        bit_cnt_n  = bit_cnt;
        cs_nxt     = chipSelect;
        sclk_nxt   = sclk;
        mosi_nxt   = mosi;
        busy_nxt   = busy;
        done_nxt   = 1'b0;
        rx_nxt     = rx_data;
        load       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n    = ST_SETUP;
                    shift_tx_n = {tx_addr, tx_data};
                    shift_rx_n = 8'd0;
                    bit_cnt_n  = '0;
                    cs_nxt     = 1'b0;
                    busy_nxt   = 1'b1;
                    load       = 1'b1;
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    state_n  = ST_SCLK_HI;
                    sclk_nxt = 1'b1;
                    mosi_nxt = shift_tx[7];
                    load     = 1'b1;
                end
            end
            ST_SCLK_HI: begin
                if (tick) begin
                    state_n    = ST_SCLK_LO;
                    sclk_nxt   = 1'b0;
                    shift_rx_n = {shift_rx[6:0], miso};
                    shift_tx_n = {shift_tx[6:0], 1'b0};
                    bit_cnt_n  = bit_cnt + CNT_W'(1);
                    load       = 1'b1;
                end
            end
            ST_SCLK_LO: begin
                if (tick) begin
                    load = 1'b1;
                    // A full frame wraps the counter back to FRAME_LEN modulo its width.
                    if (bit_cnt == CNT_W'(FRAME_LEN)) begin
                        state_n = ST_HOLD;
                    end else begin
                        state_n  = ST_SCLK_HI;
                        sclk_nxt = 1'b1;
                        mosi_nxt = shift_tx[7];
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    state_n  = ST_DONE;
                    cs_nxt   = 1'b1;
                    done_nxt = 1'b1;
                    mosi_nxt = 1'b0;
                    rx_nxt   = shift_rx;
                end
            end
            ST_DONE: begin
                state_n  = ST_IDLE;
                busy_nxt = 1'b0;
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_master_mode1.sv
// tb/tb_spi_master_mode1.sv - self-checking bench for spi_master_mode1 at CLK_DIV 2 and 1.
module tb_spi_master_mode1;

    logic clk = 1'b0;
    logic rst, start, tx_addr, miso, sel;
    logic [6:0] tx_data;
    logic cs1, sclk1, mosi1, busy1, done1, cs2, sclk2, mosi2, busy2, done2;
    logic [7:0] rx1, rx2;
    logic cs, sclk, mosi, busy, done;
    logic [7:0] rx_data;
    int checks, errors, div;

    logic [7:0] obs_mosi, obs_rx;
    int obs_rises, obs_done_cyc, obs_dones, obs_cs_low;
    logic obs_busy_end, obs_cs0, obs_busy0;

    always #5 clk = ~clk;

    spi_master_mode1 #(.CLK_DIV(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .tx_addr(tx_addr), .tx_data(tx_data), .miso(miso),
        .chipSelect(cs2), .sclk(sclk2), .mosi(mosi2), .rx_data(rx2), .busy(busy2), .done(done2)
    );
    spi_master_mode1 #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .tx_addr(tx_addr), .tx_data(tx_data), .miso(miso),
        .chipSelect(cs1), .sclk(sclk1), .mosi(mosi1), .rx_data(rx1), .busy(busy1), .done(done1)
    );

    assign cs      = sel ? cs1   : cs2;
    assign sclk    = sel ? sclk1 : sclk2;
    assign mosi    = sel ? mosi1 : mosi2;
    assign busy    = sel ? busy1 : busy2;
    assign done    = sel ? done1 : done2;
    assign rx_data = sel ? rx1   : rx2;

    task automatic wait_idle();
        int n = 0;
        while (!(busy === 1'b0 && cs === 1'b1) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL idle_timeout: busy=%b cs=%b required busy=0 cs=1", busy, cs);
        end
    endtask

    // mode 0: plain, 1: tx inputs change at E0+3, 2: start re-pulsed mid-frame and in DONE
    task automatic run_frame(input logic a, input logic [6:0] d, input logic [7:0] mbits, input int mode);
        int k;
        logic prev_sclk;
        wait_idle();
        tx_addr = a; tx_data = d; start = 1'b1; miso = 1'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        obs_cs0 = cs; obs_busy0 = busy; obs_mosi = 8'd0; obs_rx = 8'hxx;
        obs_rises = 0; obs_done_cyc = -1; obs_dones = 0;
        obs_cs_low = (cs === 1'b0) ? 1 : 0;
        prev_sclk = sclk; k = 0;
        for (int cyc = 1; cyc <= 18 * div + 6; cyc++) begin
            if (mode == 1 && cyc == 3) begin tx_addr = ~a; tx_data = ~d; end
            if (mode == 2 && (cyc == 5 || cyc == 20 || cyc == 18 * div + 1)) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            if (cs === 1'b0) obs_cs_low++;
            if (sclk === 1'b1 && prev_sclk !== 1'b1) begin
                obs_mosi = {obs_mosi[6:0], mosi};
                if (k < 8) miso = mbits[7-k];
                k++;
                obs_rises++;
            end
            prev_sclk = sclk;
            if (done === 1'b1) begin
                obs_dones++;
                if (obs_done_cyc < 0) begin obs_done_cyc = cyc; obs_rx = rx_data; end
            end
        end
        obs_busy_end = busy;
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (cs2 !== 1'b1 || cs1 !== 1'b1) begin errors++; $display("FAIL reset_cs: got %b/%b required 1", cs2, cs1); end
        checks++; if (sclk2 !== 1'b0 || sclk1 !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b/%b required 0", sclk2, sclk1); end
        checks++; if (mosi2 !== 1'b0 || busy2 !== 1'b0 || done2 !== 1'b0) begin errors++; $display("FAIL reset_ctl: mosi=%b busy=%b done=%b required 0", mosi2, busy2, done2); end
        checks++; if (rx2 !== 8'h00 || rx1 !== 8'h00) begin errors++; $display("FAIL reset_rx: got %h/%h required 00", rx2, rx1); end
    endtask

    task automatic test_basic();
        run_frame(1'b0, 7'h55, 8'($urandom), 0);
        checks++; if (obs_cs0 !== 1'b0 || obs_busy0 !== 1'b1) begin errors++; $display("FAIL basic_e0: cs=%b busy=%b required cs=0 busy=1", obs_cs0, obs_busy0); end
        checks++; if (obs_mosi !== 8'h55) begin errors++; $display("FAIL basic_mosi: got %h required 55", obs_mosi); end
        checks++; if (obs_rises !== 8) begin errors++; $display("FAIL basic_rises: got %0d required 8", obs_rises); end
        checks++; if (obs_done_cyc !== 18 * div) begin errors++; $display("FAIL basic_done_cyc: got %0d required %0d", obs_done_cyc, 18 * div); end
        checks++; if (obs_cs_low !== 18 * div) begin errors++; $display("FAIL basic_cs_low: got %0d required %0d", obs_cs_low, 18 * div); end
        checks++; if (obs_dones !== 1 || obs_busy_end !== 1'b0) begin errors++; $display("FAIL basic_end: dones=%0d busy=%b required 1/0", obs_dones, obs_busy_end); end
    endtask

    task automatic test_miso();
        run_frame(1'b1, 7'h00, 8'b1011_0010, 0);
        checks++; if (obs_rx !== 8'hB2) begin errors++; $display("FAIL miso_rx: got %h required b2", obs_rx); end
        checks++; if (obs_mosi !== 8'h80) begin errors++; $display("FAIL miso_mosi: got %h required 80", obs_mosi); end
    endtask

    task automatic test_repulse();
        run_frame(1'($urandom), 7'($urandom), 8'($urandom), 2);
        checks++; if (obs_rises !== 8) begin errors++; $display("FAIL repulse_rises: got %0d required 8", obs_rises); end
        checks++; if (obs_dones !== 1) begin errors++; $display("FAIL repulse_dones: got %0d required 1", obs_dones); end
        checks++; if (obs_cs_low !== 18 * div || obs_busy_end !== 1'b0) begin errors++; $display("FAIL repulse_cs: cs_low=%0d busy=%b required %0d/0", obs_cs_low, obs_busy_end, 18 * div); end
    endtask

    task automatic test_tx_change();
        logic a;
        logic [6:0] d;
        a = 1'($urandom); d = 7'($urandom);
        run_frame(a, d, 8'($urandom), 1);
        checks++; if (obs_mosi !== {a, d}) begin errors++; $display("FAIL tx_change_mosi: got %h required %h", obs_mosi, {a, d}); end
    endtask

    task automatic test_random();
        logic a;
        logic [6:0] d;
        logic [7:0] m;
        for (int i = 0; i < 4; i++) begin
            a = 1'($urandom); d = 7'($urandom); m = 8'($urandom);
            run_frame(a, d, m, 0);
            checks++; if (obs_mosi !== {a, d}) begin errors++; $display("FAIL rand_mosi[%0d]: got %h required %h", i, obs_mosi, {a, d}); end
            checks++; if (obs_rx !== m) begin errors++; $display("FAIL rand_rx[%0d]: got %h required %h", i, obs_rx, m); end
            checks++; if (obs_done_cyc !== 18 * div) begin errors++; $display("FAIL rand_done[%0d]: got %0d required %0d", i, obs_done_cyc, 18 * div); end
        end
    endtask

    task automatic test_reset_mid();
        logic a;
        logic [6:0] d;
        logic [7:0] m;
        run_frame(1'b1, 7'h11, 8'hA5, 0);
        checks++; if (obs_rx !== 8'hA5) begin errors++; $display("FAIL pre_reset_rx: got %h required a5", obs_rx); end
        tx_addr = 1'b1; tx_data = 7'h7F; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 10; c++) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (cs !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_ctl: cs=%b sclk=%b busy=%b required 1/0/0", cs, sclk, busy); end
        checks++; if (done !== 1'b0 || rx_data !== 8'h00) begin errors++; $display("FAIL midrst_rx: done=%b rx=%h required 0/00", done, rx_data); end
        rst = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            checks++; if (sclk !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_quiet[%0d]: sclk=%b done=%b required 0/0", c, sclk, done); end
        end
        a = 1'($urandom); d = 7'($urandom); m = 8'($urandom);
        run_frame(a, d, m, 0);
        checks++; if (obs_mosi !== {a, d} || obs_rx !== m) begin errors++; $display("FAIL midrst_clean: mosi=%h rx=%h required %h/%h", obs_mosi, obs_rx, {a, d}, m); end
        checks++; if (obs_done_cyc !== 18 * div || obs_rises !== 8) begin errors++; $display("FAIL midrst_clean_timing: done=%0d rises=%0d required %0d/8", obs_done_cyc, obs_rises, 18 * div); end
    endtask

    task automatic test_back_to_back();
        int rises, dones;
        logic prev_sclk, exp_cs, exp_done;
        sel = 1'b1; div = 1;
        do_reset();
        rises = 0; dones = 0; prev_sclk = 1'b0;
        tx_addr = 1'($urandom); tx_data = 7'($urandom);
        start = 1'b1;
        for (int t = 0; t < 60; t++) begin
            @(posedge clk); #1;
            exp_cs = ((t % 20) >= 18);
            exp_done = ((t % 20) == 18);
            checks++; if (cs !== exp_cs) begin errors++; $display("FAIL b2b_cs[%0d]: got %b required %b", t, cs, exp_cs); end
            checks++; if (done !== exp_done) begin errors++; $display("FAIL b2b_done[%0d]: got %b required %b", t, done, exp_done); end
            checks++; if (sclk === 1'b1 && cs !== 1'b0) begin errors++; $display("FAIL b2b_glitch[%0d]: sclk=1 with cs=%b required cs=0", t, cs); end
            if (sclk === 1'b1 && prev_sclk !== 1'b1) rises++;
            if (done === 1'b1) dones++;
            prev_sclk = sclk;
        end
        start = 1'b0;
        checks++; if (rises !== 24) begin errors++; $display("FAIL b2b_rises: got %0d required 24", rises); end
        checks++; if (dones !== 3) begin errors++; $display("FAIL b2b_dones: got %0d required 3", dones); end
    endtask

    initial begin
        checks = 0; errors = 0;
        sel = 1'b0; div = 2;
        rst = 1'b0; start = 1'b0; tx_addr = 1'b0; tx_data = 7'd0; miso = 1'b0;
        test_reset();
        test_basic();
        test_miso();
        test_repulse();
        test_tx_change();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
